// File: rtl/i2c_reg_access_seq.sv
// Sequences an I2C byte controller through single-byte register write/read transactions.
// Define I2C_SEQ_RETRY_EN to restart a NACKed transaction up to RETRY_MAX extra times.
module i2c_reg_access_seq #(
    parameter int REG_AW    = 8,
    parameter int RETRY_MAX = 3
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              req,
    input  logic              rw,
    input  logic [6:0]        dev_addr,
    input  logic [REG_AW-1:0] reg_addr,
    input  logic [7:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              err_nack,
    output logic              err_al,
    output logic              bc_start,
    output logic              bc_stop,
    output logic              bc_read,
    output logic              bc_write,
    output logic              bc_ack_in,
    output logic [7:0]        bc_din,
    input  logic              bc_cmd_ack,
    input  logic              bc_ack_out,
    input  logic [7:0]        bc_dout,
    input  logic              bc_al,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_W, S_REG_HI, S_REG_LO, S_WDATA, S_DEV_R, S_RDATA, S_STOP, S_DONE
    } state_e;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       write;
        logic       ack_in;
        logic [7:0] din;
    } cmd_t;

    state_e      state_q;
    cmd_t        cmd_q;
    logic        rw_q;
    logic [6:0]  dev_q;
    logic [15:0] reg_q;
    logic [7:0]  wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        err_nack_q;
    logic        err_al_q;
    logic [7:0]  rdata_q;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RCW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    logic [RCW-1:0] retry_q;
`endif

    // Byte command presented to the controller while sitting in a given state.
    function automatic cmd_t cmd_for(state_e st, logic [6:0] dev, logic [15:0] ra, logic [7:0] wd);
        cmd_t c;
        c = '0;
        case (st)
            S_DEV_W:  begin c.start = 1'b1; c.write = 1'b1; c.din = {dev, 1'b0}; end
            S_REG_HI: begin c.write = 1'b1; c.din = ra[15:8]; end
            S_REG_LO: begin c.write = 1'b1; c.din = ra[7:0]; end
            S_WDATA:  begin c.write = 1'b1; c.stop = 1'b1; c.din = wd; end
            S_DEV_R:  begin c.start = 1'b1; c.write = 1'b1; c.din = {dev, 1'b1}; end
            S_RDATA:  begin c.read = 1'b1; c.ack_in = 1'b1; c.stop = 1'b1; end
            S_STOP:   c.stop = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

    function automatic state_e next_on_ack(state_e st, logic is_read);
        state_e n;
        case (st)
            S_DEV_W:  n = (REG_AW == 16) ? S_REG_HI : S_REG_LO;
            S_REG_HI: n = S_REG_LO;
            S_REG_LO: n = is_read ? S_DEV_R : S_WDATA;
            S_DEV_R:  n = S_RDATA;
            default:  n = S_DONE;
        endcase
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            rw_q       <= 1'b0;
            dev_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_nack_q <= 1'b0;
            err_al_q   <= 1'b0;
            rdata_q    <= '0;
`ifdef I2C_SEQ_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        rw_q       <= rw;
                        dev_q      <= dev_addr;
                        reg_q      <= 16'(reg_addr);
                        wdata_q    <= wdata;
                        err_nack_q <= 1'b0;
                        err_al_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        cmd_q      <= cmd_for(S_DEV_W, dev_addr, 16'(reg_addr), wdata);
                        state_q    <= S_DEV_W;
`ifdef I2C_SEQ_RETRY_EN
                        retry_q    <= '0;
`endif
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: begin
                    // Lost arbitration: the controller has already released the bus, so no STOP.
                    if (bc_al) begin
                        err_al_q <= 1'b1;
                        state_q  <= S_DONE;
                        cmd_q    <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (bc_cmd_ack) begin
                        case (state_q)
                            S_DEV_W, S_REG_HI, S_REG_LO, S_DEV_R: begin
                                if (bc_ack_out) begin
                                    state_q <= S_STOP;
                                    cmd_q   <= cmd_for(S_STOP, dev_q, reg_q, wdata_q);
                                end else begin
                                    state_q <= next_on_ack(state_q, rw_q);
                                    cmd_q   <= cmd_for(next_on_ack(state_q, rw_q), dev_q, reg_q, wdata_q);
                                end
                            end
                            S_WDATA: begin
                                err_nack_q <= bc_ack_out;
                                state_q    <= S_DONE;
                                cmd_q      <= '0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                            end
                            S_RDATA: begin
                                rdata_q <= bc_dout;
                                state_q <= S_DONE;
                                cmd_q   <= '0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                            S_STOP: begin
`ifdef I2C_SEQ_RETRY_EN
                                if (int'(retry_q) < RETRY_MAX) begin
                                    retry_q <= retry_q + RCW'(1);
                                    state_q <= S_DEV_W;
                                    cmd_q   <= cmd_for(S_DEV_W, dev_q, reg_q, wdata_q);
                                end else begin
                                    err_nack_q <= 1'b1;
                                    state_q    <= S_DONE;
                                    cmd_q      <= '0;
                                    busy_q     <= 1'b0;
                                    done_q     <= 1'b1;
                                end
`else
                                err_nack_q <= 1'b1;
                                state_q    <= S_DONE;
                                cmd_q      <= '0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign err_nack  = err_nack_q;
    assign err_al    = err_al_q;
    assign bc_start  = cmd_q.start;
    assign bc_stop   = cmd_q.stop;
    assign bc_read   = cmd_q.read;
    assign bc_write  = cmd_q.write;
    assign bc_ack_in = cmd_q.ack_in;
    assign bc_din    = cmd_q.din;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_reg_access_seq.sv
// Bench for i2c_reg_access_seq: byte-controller/slave model, list-based reference model, scoreboard monitor.
`timescale 1ns/1ps
module tb_i2c_reg_access_seq;

    localparam int REG_AW    = 8;
    localparam int RETRY_MAX = 3;
    localparam int NB_ADDR   = REG_AW / 8;

    logic              clk = 1'b0;
    logic              nReset;
    logic              req;
    logic              rw;
    logic [6:0]        dev_addr;
    logic [REG_AW-1:0] reg_addr;
    logic [7:0]        wdata;
    logic              busy, done, err_nack, err_al;
    logic [7:0]        rdata;
    logic              bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
    logic [7:0]        bc_din;
    logic              bc_cmd_ack, bc_ack_out, bc_al;
    logic [7:0]        bc_dout;
    logic [3:0]        dbg_state;

    always #5 clk = ~clk;

    i2c_reg_access_seq #(.REG_AW(REG_AW), .RETRY_MAX(RETRY_MAX)) dut (
        .clk(clk), .nReset(nReset), .req(req), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .err_nack(err_nack), .err_al(err_al), .bc_start(bc_start), .bc_stop(bc_stop),
        .bc_read(bc_read), .bc_write(bc_write), .bc_ack_in(bc_ack_in), .bc_din(bc_din),
        .bc_cmd_ack(bc_cmd_ack), .bc_ack_out(bc_ack_out), .bc_dout(bc_dout), .bc_al(bc_al),
        .dbg_state(dbg_state)
    );

    // Command word: {start, stop, read, write, ack_in, din}
    logic [12:0] exp_cmd_q[$];
    // Result word: {check_rdata, rdata, err_nack, err_al}
    logic [10:0] exp_res_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int          plan_nack = -1;
    int          plan_al   = -1;
    logic [7:0]  plan_rd   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the transaction as a list of byte commands, trimmed by the NACK / arbitration plan.
    task automatic ref_txn(input logic rw_v, input logic [6:0] dev_v, input logic [REG_AW-1:0] reg_v,
                           input logic [7:0] wd_v, input int nack_i, input int al_i, input logic [7:0] rd_v);
        logic [12:0] seq[$];
        logic [15:0] r16;
        int attempts;
        r16 = 16'(reg_v);
        seq = {};
        seq.push_back({5'b10010, dev_v, 1'b0});
        if (REG_AW == 16) seq.push_back({5'b00010, r16[15:8]});
        seq.push_back({5'b00010, r16[7:0]});
        if (!rw_v) seq.push_back({5'b01010, wd_v});
        else begin
            seq.push_back({5'b10010, dev_v, 1'b1});
            seq.push_back({5'b01101, 8'h00});
        end
`ifdef I2C_SEQ_RETRY_EN
        attempts = RETRY_MAX + 1;
`else
        attempts = 1;
`endif
        if (al_i >= 0) begin
            for (int i = 0; i < al_i; i++) exp_cmd_q.push_back(seq[i]);
            exp_res_q.push_back({1'b0, 8'h00, 1'b0, 1'b1});
        end else if (nack_i >= 0 && nack_i == seq.size() - 1) begin
            foreach (seq[i]) exp_cmd_q.push_back(seq[i]);
            exp_res_q.push_back({1'b0, 8'h00, 1'b1, 1'b0});
        end else if (nack_i >= 0) begin
            for (int a = 0; a < attempts; a++) begin
                for (int i = 0; i <= nack_i; i++) exp_cmd_q.push_back(seq[i]);
                exp_cmd_q.push_back({5'b01000, 8'h00});
            end
            exp_res_q.push_back({1'b0, 8'h00, 1'b1, 1'b0});
        end else begin
            foreach (seq[i]) exp_cmd_q.push_back(seq[i]);
            exp_res_q.push_back({rw_v, rd_v, 1'b0, 1'b0});
        end
    endtask

    // Byte-controller + slave model: acks each command after a random delay, following the plan.
    initial begin
        int  wait_cnt;
        int  byte_idx;
        int  cur;
        bit  active;
        bc_cmd_ack = 1'b0; bc_ack_out = 1'b0; bc_al = 1'b0; bc_dout = 8'h00;
        wait_cnt = 0; byte_idx = 0; active = 1'b0;
        forever begin
            @(posedge clk); #1;
            bc_cmd_ack = 1'b0; bc_ack_out = 1'b0; bc_al = 1'b0;
            bc_dout = 8'($urandom);
            if (!nReset || !(bc_start || bc_stop || bc_read || bc_write)) begin
                active = 1'b0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end
                if (wait_cnt > 0) wait_cnt--;
                else begin
                    active = 1'b0;
                    cur = byte_idx;
                    if (bc_write || bc_read) begin
                        cur = (bc_start && !bc_din[0]) ? 0 : byte_idx + 1;
                        byte_idx = cur;
                    end
                    if ((bc_write || bc_read) && cur == plan_al) bc_al = 1'b1;
                    else begin
                        bc_cmd_ack = 1'b1;
                        bc_ack_out = bc_write && (cur == plan_nack);
                        if (bc_read) bc_dout = plan_rd;
                    end
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a command ack or a done pulse.
    initial begin
        logic [12:0] e, got;
        logic [10:0] r;
        bit al_prev;
        al_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!nReset) begin
                al_prev = 1'b0;
            end else begin
                if (al_prev) check("al_to_done", done, 1);
                al_prev = bc_al;
                if (bc_cmd_ack) begin
                    got = {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din};
                    if (exp_cmd_q.size() == 0) check("cmd_unexpected", got, 0);
                    else begin
                        e = exp_cmd_q.pop_front();
                        check("cmd_flags", got[12:8], e[12:8]);
                        if (e[9]) check("cmd_din", got[7:0], e[7:0]);
                        check("rd_wr_excl", bc_read & bc_write, 0);
                    end
                end
                if (done) begin
                    check("done_busy", busy, 0);
                    check("done_bc_idle", {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din}, 0);
                    check("cmd_leftover", exp_cmd_q.size(), 0);
                    if (exp_res_q.size() == 0) check("done_unexpected", done, 0);
                    else begin
                        r = exp_res_q.pop_front();
                        check("err_nack", err_nack, r[1]);
                        check("err_al", err_al, r[0]);
                        if (r[10]) check("rdata", rdata, r[9:2]);
                    end
                end
            end
        end
    end

    // mode 0: normal, 1: req held through busy and DONE, 2: reset while the data byte is in flight
    task automatic run_txn(input logic rw_v, input logic [6:0] dev_v, input logic [REG_AW-1:0] reg_v,
                           input logic [7:0] wd_v, input int nack_i, input int al_i,
                           input logic [7:0] rd_v, input int mode);
        int t;
        plan_nack = nack_i; plan_al = al_i; plan_rd = rd_v;
        ref_txn(rw_v, dev_v, reg_v, wd_v, nack_i, al_i, rd_v);
        req = 1'b1; rw = rw_v; dev_addr = dev_v; reg_addr = reg_v; wdata = wd_v;
        @(posedge clk); #1;
        check("accept", busy, 1);
        if (mode != 1) begin
            req = 1'b0;
            rw = 1'($urandom); dev_addr = 7'($urandom);
            reg_addr = REG_AW'($urandom); wdata = 8'($urandom);
        end
        if (mode == 2) begin
            t = 0;
            while (!(bc_write && bc_stop) && t < 200) begin @(posedge clk); #1; t++; end
            check("reach_wdata", t < 200, 1);
            nReset = 1'b0;
            @(posedge clk); #1;
            check("reset_mid_outputs", {busy, done, rdata, err_nack, err_al, bc_start, bc_stop,
                  bc_read, bc_write, bc_ack_in, bc_din, dbg_state}, 0);
            nReset = 1'b1;
            exp_cmd_q.delete();
            exp_res_q.delete();
        end else begin
            t = 0;
            while (!done && t < 400) begin @(posedge clk); #1; t++; end
            check("done_seen", t < 400, 1);
            @(posedge clk); #1;
            check("done_pulse", done, 0);
            if (mode == 1) begin
                req = 1'b0;
                check("no_accept_in_done", busy, 0);
            end
        end
        @(posedge clk); #1;
        check("idle_after", busy, 0);
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL global_timeout: got no end, expected end before 2000000ns");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        int r, nb, kind, ni, ai, mode;
        nReset = 1'b0; req = 1'b0; rw = 1'b0; dev_addr = '0; reg_addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, rdata, err_nack, err_al, bc_start, bc_stop,
              bc_read, bc_write, bc_ack_in, bc_din, dbg_state}, 0);
        nReset = 1'b1;

        run_txn(1'b0, 7'h50, REG_AW'(16'h1234), 8'hA5, -1, -1, 8'h00, 0);
        run_txn(1'b0, 7'h50, REG_AW'(16'h0010), 8'hA5, -1, -1, 8'h00, 0);
        run_txn(1'b1, 7'h50, REG_AW'(16'h0020), 8'h00, -1, -1, 8'h3C, 0);
        run_txn(1'b0, 7'h50, REG_AW'(16'h0010), 8'h5A, 0, -1, 8'h00, 0);
        run_txn(1'b0, 7'h50, REG_AW'(16'h0011), 8'h77, -1, NB_ADDR, 8'h00, 0);
        run_txn(1'b0, 7'h50, REG_AW'(16'h0012), 8'h99, -1, -1, 8'h00, 2);
        run_txn(1'b1, 7'h21, REG_AW'(16'h0044), 8'h00, -1, -1, 8'hC3, 0);
        run_txn(1'b0, 7'h33, REG_AW'(16'h0055), 8'h66, -1, -1, 8'h00, 1);
        run_txn(1'b1, 7'h50, REG_AW'(16'h0020), 8'h00, NB_ADDR + 1, -1, 8'h11, 0);
        run_txn(1'b0, 7'h50, REG_AW'(16'h0020), 8'hEE, NB_ADDR + 1, -1, 8'h00, 0);

        for (int i = 0; i < 40; i++) begin
            r    = $urandom_range(0, 1);
            nb   = NB_ADDR + 2 + r;
            kind = $urandom_range(0, 5);
            ni   = (kind == 0) ? $urandom_range(0, nb - 1 - r) : -1;
            ai   = (kind == 1) ? $urandom_range(0, nb - 1) : -1;
            mode = (i % 7 == 3) ? 1 : 0;
            run_txn(r[0], 7'($urandom), REG_AW'($urandom), 8'($urandom), ni, ai, 8'($urandom), mode);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
